// File: rtl/seven_segment_capture.sv
// seven_segment_capture
//   Recovers BCD digits from a time-multiplexed, active-high seven-segment
//   bus. Each digit has to hold steady for STABLE_CYCLES samples before it
//   is captured into its staging slot. Once every slot of a scan frame is
//   filled, the assembled word is published with a one-cycle valid strobe.
//
//   Optional feature macro: SEG_DP_EN
//     Adds decimal-point capture: the seg_dp input and the dp output.
//
//   Parameters
//     DIGITS         number of multiplexed digit positions (1..8)
//     STABLE_CYCLES  consecutive identical samples needed to accept (>=1)
//   Ports
//     clk     in   sole clock, rising edge
//     rst     in   synchronous reset, active-high
//     seg     in   [6:0] segments, bit0=a .. bit6=g, active-high
//     dig_en  in   [DIGITS-1:0] one-hot digit strobe
//     seg_dp  in   decimal point, active-high            (SEG_DP_EN only)
//     bcd     out  [4*DIGITS-1:0] captured frame, digit i at [4i+3:4i]
//     dp      out  [DIGITS-1:0] captured decimal points  (SEG_DP_EN only)
//     valid   out  one-cycle pulse when bcd updates
//     err     out  frame contained an illegal pattern; held until next valid
module seven_segment_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
`ifdef SEG_DP_EN
    input  logic                  seg_dp,
    output logic [DIGITS-1:0]     dp,
`endif
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic                  err
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    // Input stage and its one-cycle-older copy used for the stability compare
    logic [6:0]          r_s_seg, r_p_seg;
    logic [DIGITS-1:0]   r_s_en,  r_p_en;
    logic [CW-1:0]       r_cnt;

    // Staging area for the frame under construction
    logic [4*DIGITS-1:0] r_stage;
    logic [DIGITS-1:0]   r_ill;
    logic [DIGITS-1:0]   r_mask;

    // Published outputs
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_valid;
    logic                r_err;

    logic                w_changed;
    logic [CW-1:0]       w_cnt_next;
    logic                w_onehot;
    logic                w_accept;
    logic                w_full;
    logic [3:0]          w_nib;
    logic                w_illegal;
    logic [DIGITS-1:0]   w_wr;
    logic [DIGITS-1:0]   w_mask_next;
    logic [DIGITS-1:0]   w_ill_next;

`ifdef SEG_DP_EN
    logic                r_s_dp, r_p_dp;
    logic [DIGITS-1:0]   r_stage_dp;
    logic [DIGITS-1:0]   r_dp;

    assign w_changed = ({r_s_dp, r_s_seg, r_s_en} != {r_p_dp, r_p_seg, r_p_en});
    assign dp        = r_dp;
`else
    assign w_changed = ({r_s_seg, r_s_en} != {r_p_seg, r_p_en});
`endif

    // Counter tracks how many cycles the registered sample has been steady;
    // it is evaluated one step ahead so the slot is written on the edge at
    // which the count reaches STABLE_CYCLES.
    assign w_cnt_next = w_changed ? C_ONE
                      : (r_cnt == C_MAX) ? C_MAX : r_cnt + C_ONE;

    assign w_onehot = (r_s_en != '0) && ((r_s_en & (r_s_en - 1'b1)) == '0);

    // A saturated counter with unchanged input means this run was already
    // accepted; a change restarts it (covers STABLE_CYCLES=1 too).
    assign w_accept = w_onehot && (w_cnt_next == C_MAX)
                   && (w_changed || (r_cnt != C_MAX));

    assign w_full = &r_mask;
    assign w_wr   = w_accept ? r_s_en : '0;

    // Publishing clears the frame first; a coincident accept lands in the
    // fresh frame.
    assign w_mask_next = (w_full ? '0 : r_mask) | w_wr;
    assign w_ill_next  = ((w_full ? '0 : r_ill) & ~w_wr) | (w_illegal ? w_wr : '0);

    always_comb begin
        w_nib     = 4'hE;
        w_illegal = 1'b0;
        case (r_s_seg)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h6F: w_nib = 4'h9;
            7'h00: w_nib = 4'hF;
            default: begin
                w_nib     = 4'hE;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_seg <= '0;
            r_s_en  <= '0;
            r_p_seg <= '0;
            r_p_en  <= '0;
            r_cnt   <= '0;
            r_stage <= '0;
            r_ill   <= '0;
            r_mask  <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_s_seg <= seg;
            r_s_en  <= dig_en;
            r_p_seg <= r_s_seg;
            r_p_en  <= r_s_en;
            r_cnt   <= w_cnt_next;
            r_mask  <= w_mask_next;
            r_ill   <= w_ill_next;
            r_valid <= w_full;
            if (w_full) begin
                r_bcd <= r_stage;
                r_err <= |r_ill;
            end
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (w_wr[i]) begin
                    r_stage[4*i +: 4] <= w_nib;
                end
            end
        end
    end

`ifdef SEG_DP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_dp     <= 1'b0;
            r_p_dp     <= 1'b0;
            r_stage_dp <= '0;
            r_dp       <= '0;
        end else begin
            r_s_dp <= seg_dp;
            r_p_dp <= r_s_dp;
            if (w_full) begin
                r_dp <= r_stage_dp;
            end
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (w_wr[i]) begin
                    r_stage_dp[i] <= r_s_dp;
                end
            end
        end
    end
`endif

    assign bcd   = r_bcd;
    assign valid = r_valid;
    assign err   = r_err;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture (DIGITS=4, STABLE_CYCLES=4).
// A run-length model over the sampled pins predicts valid/bcd/err every
// cycle; directed frames add literal expectations on top.
module tb_seven_segment_capture;

    localparam int D  = 4;
    localparam int SC = 4;
    localparam logic [6:0] PATS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       seg;
    logic [D-1:0]     dig_en;
    logic             seg_dp;
    logic [4*D-1:0]   bcd;
    logic             valid;
    logic             err;
`ifdef SEG_DP_EN
    logic [D-1:0]     dp;
`endif

    always #5 clk = ~clk;

    seven_segment_capture #(.DIGITS(D), .STABLE_CYCLES(SC)) dut (
        .clk    (clk),
        .rst    (rst),
        .seg    (seg),
        .dig_en (dig_en),
`ifdef SEG_DP_EN
        .seg_dp (seg_dp),
        .dp     (dp),
`endif
        .bcd    (bcd),
        .valid  (valid),
        .err    (err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               cyc = 0;
    bit               started = 0;
    logic [7+D:0]     m_val;         // last sampled {dp, seg, dig_en}
    int               m_run;         // length of the run of equal samples
    logic [3:0]       m_dig [D];
    logic             m_il  [D];
    logic             m_dpv [D];
    logic [D-1:0]     m_mask;
    logic [4*D-1:0]   m_bcd;
    logic             m_valid;
    logic             m_err;
    logic [D-1:0]     m_dp;

    always @(posedge clk) begin
        logic [7+D:0] x;
        logic [6:0]   p;
        logic [D-1:0] en;
        logic [3:0]   nib;
        logic         il;
        cyc++;
        if (rst) begin
            started = 1;
            m_val   = '0;
            m_run   = 1;
            m_mask  = '0;
            m_bcd   = '0;
            m_valid = 0;
            m_err   = 0;
            m_dp    = '0;
            for (int i = 0; i < D; i++) m_il[i] = 0;
        end else begin
            m_valid = (m_mask == {D{1'b1}});
            if (m_valid) begin
                m_err = 0;
                for (int i = 0; i < D; i++) begin
                    m_bcd[4*i +: 4] = m_dig[i];
                    m_dp[i] = m_dpv[i];
                    m_err = m_err | m_il[i];
                    m_il[i] = 0;
                end
                m_mask = '0;
            end
            en = m_val[D-1:0];
            p  = m_val[D+6:D];
            if (m_run == SC && $countones(en) == 1) begin
                nib = 4'hE;
                il  = (p != 7'h00);
                if (p == 7'h00) nib = 4'hF;
                for (int k = 0; k < 10; k++)
                    if (PATS[k] == p) begin nib = 4'(k); il = 0; end
                for (int i = 0; i < D; i++)
                    if (en[i]) begin
                        m_dig[i] = nib;
                        m_il[i]  = il;
                        m_dpv[i] = m_val[D+7];
                        m_mask[i] = 1'b1;
                    end
            end
            x = {seg_dp, seg, dig_en};
            if (x == m_val) begin
                if (m_run <= SC) m_run++;
            end else begin
                m_val = x;
                m_run = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int             nv = 0;
    logic [4*D-1:0] last_bcd = '0;
    logic           last_err = 0;
    int             last_vcyc = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("valid", valid, m_valid);
            chk("bcd", bcd, m_bcd);
            chk("err", err, m_err);
`ifdef SEG_DP_EN
            chk("dp", dp, m_dp);
`endif
            if (valid === 1'b1) begin
                nv++;
                last_bcd  = bcd;
                last_err  = err;
                last_vcyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input int d, input logic [6:0] p, input logic dpb, input int n);
        seg       = p;
        dig_en    = '0;
        dig_en[d] = 1'b1;
        seg_dp    = dpb;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        seg    = '0;
        dig_en = '0;
        seg_dp = 0;
        repeat (n) @(negedge clk);
    endtask

    int n0;
    int p3;

    initial begin
        rst    = 1;
        seg    = '0;
        dig_en = '0;
        seg_dp = 0;
        repeat (3) @(negedge clk);
        chk("reset_bcd", bcd, 0);
        chk("reset_valid", valid, 0);
        chk("reset_err", err, 0);
        rst = 0;
        idle(3);

        // plain frame 0,1,2,3 and latency from first sample of digit 3
        n0 = nv;
        put(0, 7'h3F, 0, 6);
        put(1, 7'h06, 0, 6);
        put(2, 7'h5B, 0, 6);
        p3 = cyc + 1;
        put(3, 7'h4F, 0, 6);
        idle(6);
        chk("t1_count", nv - n0, 1);
        chk("t1_bcd", last_bcd, 16'h3210);
        chk("t1_err", last_err, 0);
        chk("t1_latency", last_vcyc - p3, 5);

        // glitch on digit 2: 4 for two cycles then 5
        n0 = nv;
        put(0, 7'h07, 0, 6);
        put(1, 7'h7F, 0, 6);
        put(2, 7'h66, 0, 2);
        put(2, 7'h6D, 0, 6);
        put(3, 7'h6F, 0, 6);
        idle(6);
        chk("t2_count", nv - n0, 1);
        chk("t2_bcd", last_bcd, 16'h9587);

        // illegal digit 1, then a clean frame clears err
        n0 = nv;
        put(0, 7'h06, 0, 6);
        put(1, 7'h49, 0, 6);
        put(2, 7'h5B, 0, 6);
        put(3, 7'h4F, 0, 6);
        idle(6);
        chk("t3_count", nv - n0, 1);
        chk("t3_bcd", last_bcd, 16'h32E1);
        chk("t3_err", last_err, 1);
        put(0, 7'h66, 0, 6);
        put(1, 7'h6D, 0, 6);
        put(2, 7'h7D, 0, 6);
        put(3, 7'h07, 0, 6);
        idle(6);
        chk("t3_clean_bcd", last_bcd, 16'h7654);
        chk("t3_clean_err", last_err, 0);
        chk("t3_clean_err_held", err, 0);

        // blanking and ghost intervals mid-frame do not disturb the mask
        n0 = nv;
        put(0, 7'h7F, 0, 6);
        put(1, 7'h6F, 0, 6);
        seg = 7'h06; dig_en = '0;
        repeat (20) @(negedge clk);
        seg = 7'h06; dig_en = 4'b0011;
        repeat (20) @(negedge clk);
        chk("t4_no_valid", nv - n0, 0);
        put(2, 7'h00, 0, 6);
        put(3, 7'h3F, 0, 6);
        idle(6);
        chk("t4_count", nv - n0, 1);
        chk("t4_bcd", last_bcd, 16'h0F98);

        // reset mid-frame discards partial capture
        n0 = nv;
        put(0, 7'h3F, 0, 6);
        put(1, 7'h3F, 0, 6);
        put(2, 7'h3F, 0, 6);
        rst = 1;
        repeat (2) @(negedge clk);
        chk("t5_rst_bcd", bcd, 0);
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_err", err, 0);
        rst = 0;
        idle(3);
        put(0, 7'h6F, 0, 6);
        put(1, 7'h7F, 0, 6);
        put(2, 7'h07, 0, 6);
        put(3, 7'h7D, 0, 6);
        idle(6);
        chk("t5_count", nv - n0, 1);
        chk("t5_bcd", last_bcd, 16'h6789);

`ifdef SEG_DP_EN
        n0 = nv;
        put(0, 7'h7F, 1, 6);
        put(1, 7'h3F, 0, 6);
        put(2, 7'h3F, 0, 6);
        put(3, 7'h3F, 0, 6);
        idle(6);
        chk("t6_count", nv - n0, 1);
        chk("t6_bcd", last_bcd, 16'h0008);
        chk("t6_dp", dp, 4'b0001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
